// File: rtl/mm_cdc_reg_bridge.sv
// Memory-mapped bus to per-channel register clock domain bridge.
// Each channel crosses via a 4-phase req/ack handshake with held data.
module mm_cdc_reg_bridge #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_W = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 1023,
  parameter logic [2**ADDR_SIZE-1:0] RO_MASK = '0
) (
  input  logic                            mm_clk,
  input  logic                            rst,
  input  logic [ADDR_SIZE-1:0]            mm_address,
  input  logic                            mm_read,
  input  logic                            mm_write,
  input  logic [DATA_W-1:0]               mm_writedata,
  input  logic [DATA_W/8-1:0]             mm_byteenable,
  output logic                            mm_waitrequest,
  output logic [DATA_W-1:0]               mm_readdata,
  output logic                            mm_readdatavalid,
  output logic                            mm_writeresponsevalid,
  output logic [1:0]                      mm_response,
  input  logic [2**ADDR_SIZE-1:0]         reg_clk,
  output logic [2**ADDR_SIZE-1:0]         reg_write,
  output logic [DATA_W/8-1:0]             reg_byteenable,
  output logic [DATA_W-1:0]               reg_writedata,
  input  logic [(2**ADDR_SIZE)*DATA_W-1:0] reg_readdata,
  output logic [15:0]                     timeout_count
);

  localparam int AC = 2**ADDR_SIZE;
  localparam int BE_W = DATA_W/8;
  localparam logic [15:0] TO = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_SLV = 2'b10;
  localparam logic [1:0] R_DEC = 2'b11;

  logic [1:0]           r_state;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [BE_W-1:0]      r_be;
  logic                 r_is_wr;
  logic [AC-1:0]        r_req;
  logic [1:0]           r_resp;
  logic [DATA_W-1:0]    r_rdata;
  logic [15:0]          r_tcnt;
  logic [15:0]          r_tocnt;
  logic [AC-1:0]        r_stale;
  logic [AC-1:0]        r_ping;
  logic [AC-1:0]        r_pdone;
  logic                 r_rdv;
  logic                 r_wrv;
  logic [1:0]           r_mresp;
  logic [DATA_W-1:0]    r_mrdata;

  logic [AC-1:0]        w_ack;
  logic [AC-1:0]        w_pecho;
  logic [DATA_W-1:0]    w_cap [AC];
  logic                 w_busy;
  logic                 w_bad;

  assign w_busy = r_stale[mm_address] | w_ack[mm_address] |
                  r_req[mm_address];
  assign w_bad  = (mm_write & RO_MASK[mm_address]) |
                  (mm_byteenable == '0);

  assign mm_waitrequest        = (r_state != S_RESP);
  assign mm_readdata           = r_mrdata;
  assign mm_readdatavalid      = r_rdv;
  assign mm_writeresponsevalid = r_wrv;
  assign mm_response           = r_mresp;
  assign reg_writedata         = r_wdata;
  assign reg_byteenable        = r_be;
  assign timeout_count         = r_tocnt;

  // Bus-side access FSM, timeout tracking and stale-channel draining.
  // A timed-out channel is pinged through a second handshake so the
  // bridge knows its register side has flushed before reuse.
  always_ff @(posedge mm_clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_is_wr  <= 1'b0;
      r_req    <= '0;
      r_resp   <= R_OK;
      r_rdata  <= '0;
      r_tcnt   <= '0;
      r_tocnt  <= '0;
      r_stale  <= '0;
      r_ping   <= '0;
      r_pdone  <= '0;
      r_rdv    <= 1'b0;
      r_wrv    <= 1'b0;
      r_mresp  <= R_OK;
      r_mrdata <= '0;
    end else begin
      r_rdv <= 1'b0;
      r_wrv <= 1'b0;
      for (int i = 0; i < AC; i++) begin
        if (r_stale[i]) begin
          if (!r_pdone[i] && !r_ping[i] && !w_pecho[i]) begin
            r_ping[i] <= 1'b1;
          end else if (r_ping[i] && w_pecho[i]) begin
            r_ping[i]  <= 1'b0;
            r_pdone[i] <= 1'b1;
          end else if (r_pdone[i] && !w_pecho[i]) begin
            r_pdone[i] <= 1'b0;
            r_stale[i] <= 1'b0;
          end
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (mm_read || mm_write) begin
            r_addr  <= mm_address;
            r_wdata <= mm_writedata;
            r_be    <= mm_byteenable;
            r_is_wr <= mm_write;
            r_rdata <= '0;
            if (w_bad) begin
              r_resp  <= R_DEC;
              r_state <= S_RESP;
            end else if (w_busy) begin
              r_resp  <= R_SLV;
              r_state <= S_RESP;
            end else begin
              r_req[mm_address] <= 1'b1;
              r_tcnt            <= '0;
              r_state           <= S_REQ;
            end
          end
        end
        S_REQ, S_REL: begin
          if (r_tcnt == TO) begin
            r_req[r_addr]   <= 1'b0;
            r_stale[r_addr] <= 1'b1;
            r_ping[r_addr]  <= 1'b0;
            r_pdone[r_addr] <= 1'b0;
            r_resp          <= R_SLV;
            r_rdata         <= '0;
            r_state         <= S_RESP;
            if (r_tocnt != 16'hFFFF) begin
              r_tocnt <= r_tocnt + 16'd1;
            end
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
            if (r_state == S_REQ && w_ack[r_addr]) begin
              r_rdata       <= w_cap[r_addr];
              r_req[r_addr] <= 1'b0;
              r_state       <= S_REL;
            end else if (r_state == S_REL && !w_ack[r_addr]) begin
              r_resp  <= R_OK;
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_rdv    <= !r_is_wr;
          r_wrv    <= r_is_wr;
          r_mresp  <= r_resp;
          r_mrdata <= r_rdata;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < AC; g++) begin : g_ch
    logic [SYNC_STAGES:0]   r_rs;
    logic [SYNC_STAGES-1:0] r_ps;
    logic [SYNC_STAGES-1:0] r_as;
    logic [SYNC_STAGES-1:0] r_pe;
    logic                   r_wr;
    logic [DATA_W-1:0]      r_cap;
    logic                   w_rise;

    assign w_rise = r_rs[SYNC_STAGES-1] & ~r_rs[SYNC_STAGES];

    // Register side: synchronize req/ping, pulse write, capture read data.
    // Ack is taken from the edge-detect flop so it never precedes r_cap.
    always_ff @(posedge reg_clk[g] or posedge rst) begin
      if (rst) begin
        r_rs  <= '0;
        r_ps  <= '0;
        r_wr  <= 1'b0;
        r_cap <= '0;
      end else begin
        r_rs <= {r_rs[SYNC_STAGES-1:0], r_req[g]};
        r_ps <= {r_ps[SYNC_STAGES-2:0], r_ping[g]};
        r_wr <= w_rise & r_is_wr;
        if (w_rise && !r_is_wr) begin
          r_cap <= reg_readdata[g*DATA_W +: DATA_W];
        end
      end
    end

    // Bus side: synchronize ack and ping echo back into mm_clk.
    always_ff @(posedge mm_clk or posedge rst) begin
      if (rst) begin
        r_as <= '0;
        r_pe <= '0;
      end else begin
        r_as <= {r_as[SYNC_STAGES-2:0], r_rs[SYNC_STAGES]};
        r_pe <= {r_pe[SYNC_STAGES-2:0], r_ps[SYNC_STAGES-1]};
      end
    end

    assign w_ack[g]   = r_as[SYNC_STAGES-1];
    assign w_pecho[g] = r_pe[SYNC_STAGES-1];
    assign reg_write[g] = r_wr;
    assign w_cap[g]   = r_cap;
  end

endmodule

// File: doc/mm_cdc_reg_bridge.md
MM_CDC_REG_BRIDGE -- requirements
Module: mm_cdc_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 3, meaning register channel address width; ADDR_COUNT = 2**ADDR_SIZE channels.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width, multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth in each direction, legal range 2..4.
REQ-004 SHALL have parameter TIMEOUT, default 1023, meaning the mm_clk-cycle budget per access, legal range 1..65535.
REQ-005 SHALL have parameter RO_MASK, default 0 (ADDR_COUNT bits), meaning a bit set marks that channel read-only.
REQ-006 SHALL have port mm_clk  in  1  bus clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports mm_address in ADDR_SIZE; mm_read in 1; mm_write in 1; mm_writedata in DATA_W; mm_byteenable in BE_W.
REQ-008 SHALL have ports mm_waitrequest out 1; mm_readdata out DATA_W; mm_readdatavalid out 1; mm_writeresponsevalid out 1; mm_response out 2 (00 OK, 10 SLVERR, 11 DECERR).
REQ-009 SHALL have ports reg_clk in [ADDR_COUNT]; reg_write out [ADDR_COUNT]; reg_byteenable out BE_W; reg_writedata out DATA_W; reg_readdata in DATA_W [ADDR_COUNT].
REQ-010 SHALL have port timeout_count  out  16  saturating count of timed-out accesses.

Function
REQ-011 mm-side FSM SHALL have states IDLE, REQ_WAIT, REL_WAIT, RESP; mm_waitrequest SHALL be 1 in every state except RESP.
REQ-012 In IDLE with mm_read or mm_write, the block SHALL latch address, writedata and byteenable and assign the op (write wins if both are set). It SHALL then go to RESP with DECERR if the op is a write to an RO_MASK channel or has byteenable == 0, otherwise set req[addr] and go to REQ_WAIT.
REQ-013 Per channel, a 4-phase handshake: req SHALL be synchronized into reg_clk[i] through SYNC_STAGES flops, and ack SHALL be the synchronized req, returned through SYNC_STAGES mm_clk flops.
REQ-014 On the synchronized req rising edge, reg_write[i] SHALL pulse for exactly one reg_clk[i] cycle when the op is a write, with reg_writedata/reg_byteenable held stable from REQ_WAIT entry through REL_WAIT exit.
REQ-015 On the synchronized req rising edge for a read, reg_readdata[i] SHALL be captured in the reg_clk[i] domain and held until the next req rise.
REQ-016 In REQ_WAIT, on a synchronized ack rise, the block SHALL copy the captured read data into the mm_clk domain, clear req, and go to REL_WAIT.
REQ-017 In REL_WAIT, on a synchronized ack fall, the block SHALL go to RESP with OK.
REQ-018 A timeout counter SHALL start at 0 on REQ_WAIT entry and increment each cycle in REQ_WAIT/REL_WAIT. On reaching TIMEOUT, the block SHALL clear req, go to RESP with SLVERR and readdata 0, and increment timeout_count, saturating at 16'hFFFF.
REQ-019 A channel whose ack is still high, or whose req/ack disagree after a timeout, SHALL be busy; an access to a busy channel in IDLE SHALL go directly to RESP with SLVERR without touching req.
REQ-020 RESP SHALL last exactly one cycle with mm_waitrequest 0, then return to IDLE.
REQ-021 mm_readdatavalid (reads) or mm_writeresponsevalid (writes) SHALL pulse for one cycle, exactly one cycle after RESP, together with mm_response; mm_readdata SHALL be valid in that same cycle.
REQ-022 Only one access SHALL be outstanding at a time; bus inputs SHALL be ignored outside IDLE.
REQ-023 Minimum access latency SHALL be 2*(SYNC_STAGES+1) reg/mm crossings plus 2 mm_clk cycles; no data SHALL cross domains except via the req/ack-qualified holding registers.

Reset
REQ-024 rst SHALL force, asynchronously: state IDLE, mm_waitrequest 1, mm_readdatavalid 0, mm_writeresponsevalid 0, mm_response 00, mm_readdata 0, all req 0, timeout_count 0.
REQ-025 rst SHALL clear all synchronizer flops in both domains and force reg_write 0 and reg_writedata/reg_byteenable 0.
REQ-026 rst asserted mid-access SHALL abort the access with no response pulse, and no reg_write SHALL occur after rst deasserts.

Verification
REQ-027 Write 0xDEADBEEF, BE 4'b1111, addr 3, reg_clk 3x slower than mm_clk -> exactly one reg_write[3] pulse with reg_writedata 0xDEADBEEF; writeresponsevalid with 00.
REQ-028 Read addr 5 with reg_readdata[5]=0x12345678 -> readdatavalid one cycle after waitrequest low, readdata 0x12345678, response 00.
REQ-029 Write with BE 4'b0010, data 0x0000AB00, to addr 1 -> reg_byteenable 4'b0010; write with BE 0 -> DECERR and no reg_write.
REQ-030 RO_MASK bit 2 set, write addr 2 -> DECERR within 2 cycles, reg_write[2] never pulses; a read of addr 2 succeeds.
REQ-031 reg_clk[4] stopped, read addr 4, TIMEOUT=50 -> SLVERR readdata 0 at cycle 51, timeout_count 1. A second access to addr 4 -> immediate SLVERR. Restarting the clock -> channel drains, and the next access returns OK.
REQ-032 Assert rst during REQ_WAIT of a write -> all outputs take reset values; no response pulse and no reg_write after release.
